// File: rtl/alu_slice_seq.sv
// Bit-slice ALU and register-file datapath (2901-style 9-bit micro-op).
// Adds registered status flags and an iterative unsigned multiply/divide
// sequencer. The sequencer borrows the Q register and one RAM word for its
// result and uses a start/busy/done handshake.
module alu_slice_seq #(
  parameter int WIDTH = 16,
  parameter int REGS  = 16,
  localparam int AW   = $clog2(REGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [8:0]       i,
  input  logic [AW-1:0]    a_addr,
  input  logic [AW-1:0]    b_addr,
  input  logic [WIDTH-1:0] d,
  input  logic             oe_n,
  input  logic             c0,
  input  logic             ram_lsb_in,
  input  logic             ram_msb_in,
  input  logic             q_lsb_in,
  input  logic             q_msb_in,
  output logic             ram_lsb_out,
  output logic             ram_msb_out,
  output logic             q_lsb_out,
  output logic             q_msb_out,
  output logic [WIDTH-1:0] y,
  output logic             c_out,
  output logic             g_n,
  output logic             p_n,
  output logic             ovr,
  output logic             f_msb,
  output logic             f_zero,
  input  logic             flag_we,
  output logic [3:0]       flags,
  input  logic             op_start,
  input  logic             op_kind,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  // NOTE: the register file has no reset; its contents must survive reset.
  logic [WIDTH-1:0] ram_q [REGS];
  logic [WIDTH-1:0] q_q, m_q, hi_q, lo_q;
  logic [3:0]       flags_q;
  logic [CW-1:0]    cnt_q;
  logic [AW-1:0]    baddr_q;
  logic             kind_q, busy_q, done_q, div_zero_q;
  state_t           state_q;

  logic [2:0] src, fn, dst;
  assign src = i[2:0];
  assign fn  = i[5:3];
  assign dst = i[8:6];

  logic [WIDTH-1:0] a_data, b_data;
  assign a_data = ram_q[a_addr];
  assign b_data = ram_q[b_addr];

  logic [WIDTH-1:0] r_op, s_op, r_add, s_add, f;
  logic [WIDTH:0]   sum;
  logic             gen;

  // ALU: operand select, function, carry/overflow and lookahead status.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    r_op = '0;
    s_op = '0;
    case (src)
      3'b000:  begin r_op = a_data; s_op = q_q;    end
      3'b001:  begin r_op = a_data; s_op = b_data; end
      3'b010:  begin r_op = '0;     s_op = q_q;    end
      3'b011:  begin r_op = '0;     s_op = b_data; end
      3'b100:  begin r_op = '0;     s_op = a_data; end
      3'b101:  begin r_op = d;      s_op = a_data; end
      3'b110:  begin r_op = d;      s_op = q_q;    end
      default: begin r_op = d;      s_op = '0;     end
    endcase
    // Operands as they enter the adder, so ovr/g_n/p_n describe the real sum.
    r_add = (fn == 3'b001) ? ~r_op : r_op;
    s_add = (fn == 3'b010) ? ~s_op : s_op;
    sum   = {1'b0, r_add} + {1'b0, s_add} + {{WIDTH{1'b0}}, c0};
    c_out = 1'b0;
    ovr   = 1'b0;
    case (fn)
      3'b000, 3'b001, 3'b010: begin
        f     = sum[WIDTH-1:0];
        c_out = sum[WIDTH];
        ovr   = (r_add[WIDTH-1] == s_add[WIDTH-1]) && (f[WIDTH-1] != r_add[WIDTH-1]);
      end
      3'b011:  f = r_op | s_op;
      3'b100:  f = r_op & s_op;
      3'b101:  f = ~r_op & s_op;
      3'b110:  f = r_op ^ s_op;
      default: f = ~(r_op ^ s_op);
    endcase
    gen = 1'b0;
    for (int k = 0; k < WIDTH; k++) gen = (r_add[k] & s_add[k]) | ((r_add[k] | s_add[k]) & gen);
    g_n    = !gen;
    p_n    = !(&(r_add | s_add));
    f_zero = (f == '0);
    f_msb  = f[WIDTH-1];
  end

  logic shr, shl;
  assign shr = (dst == 3'b100) || (dst == 3'b101);
  assign shl = (dst == 3'b110) || (dst == 3'b111);

  assign y           = oe_n ? {WIDTH{1'bz}} : ((dst == 3'b010) ? a_data : f);
  assign ram_lsb_out = shr ? f[0]          : 1'bz;
  assign q_lsb_out   = shr ? q_q[0]        : 1'bz;
  assign ram_msb_out = shl ? f[WIDTH-1]    : 1'bz;
  assign q_msb_out   = shl ? q_q[WIDTH-1]  : 1'bz;

  // Sequencer step: one shift-add or one restoring-divide iteration.
  logic [WIDTH:0]   mul_sum, div_sh;
  logic             div_ok, last, dz, commit;
  logic [WIDTH-1:0] hi_n, lo_n;
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    div_sh  = {hi_q, lo_q[WIDTH-1]};
    div_ok  = div_sh >= {1'b0, m_q};
    if (kind_q) begin
      hi_n = div_ok ? (div_sh[WIDTH-1:0] - m_q) : div_sh[WIDTH-1:0];
      lo_n = {lo_q[WIDTH-2:0], div_ok};
    end else begin
      hi_n = mul_sum[WIDTH:1];
      lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  assign dz     = kind_q && (m_q == '0);
  assign last   = (cnt_q == CW'(WIDTH - 1));
  assign commit = (state_q == S_RUN) && (dz || last);

  // Register-file write port: sequencer commit, or i-field write when idle.
  logic             ram_we;
  logic [AW-1:0]    ram_wa;
  logic [WIDTH-1:0] ram_wd;
  always_comb begin
    ram_we = 1'b0;
    ram_wa = b_addr;
    ram_wd = f;
    if (commit) begin
      ram_we = 1'b1;
      ram_wa = baddr_q;
      ram_wd = dz ? lo_q : hi_n;
    end else if (!busy_q && (dst == 3'b011 || shr || shl)) begin
      ram_we = 1'b1;
      if (shr)      ram_wd = {ram_msb_in, f[WIDTH-1:1]};
      else if (shl) ram_wd = {f[WIDTH-2:0], ram_lsb_in};
    end
    if (reset) ram_we = 1'b0;
  end

  // Register-file storage.
  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_wa] <= ram_wd;
  end

  // Q register, flags and the IDLE/RUN sequencer FSM.
  // NOTE: sequential state uses non-blocking assignment so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      q_q        <= '0;
      flags_q    <= '0;
      m_q        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      cnt_q      <= '0;
      kind_q     <= 1'b0;
      baddr_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (dst == 3'b000)      q_q <= f;
          else if (dst == 3'b100) q_q <= {q_msb_in, q_q[WIDTH-1:1]};
          else if (dst == 3'b110) q_q <= {q_q[WIDTH-2:0], q_lsb_in};
          if (flag_we) flags_q <= {f_zero, f_msb, c_out, ovr};
          if (op_start) begin
            m_q        <= a_data;
            lo_q       <= q_q;
            hi_q       <= '0;
            cnt_q      <= '0;
            kind_q     <= op_kind;
            baddr_q    <= b_addr;
            div_zero_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_RUN;
          end
        end
        default: begin
          hi_q  <= hi_n;
          lo_q  <= lo_n;
          cnt_q <= cnt_q + 1'b1;
          if (commit) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
            if (dz) begin
              q_q        <= '1;
              div_zero_q <= 1'b1;
              flags_q    <= {1'b0, lo_q[WIDTH-1], 1'b0, 1'b1};
            end else begin
              q_q     <= lo_n;
              flags_q <= {(hi_n == '0) && (lo_n == '0), hi_n[WIDTH-1], 1'b0, 1'b0};
            end
          end
        end
      endcase
    end
  end

  assign flags    = flags_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;

endmodule
